// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder sequencer: streams operand nibbles through one external 4-bit adder, chaining carry.
// Optional subtract mode enabled by defining NIBBLE_ADD_SUBTRACT_EN (adds op_sub input).
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   cin_in,
`ifdef NIBBLE_ADD_SUBTRACT_EN
  input  logic                   op_sub,
`endif
  output logic [3:0]             adder_a,
  output logic [3:0]             adder_b,
  output logic                   adder_cin,
  input  logic [3:0]             adder_s,
  input  logic                   adder_c,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   done_valid,
  input  logic                   done_ready,
  output logic                   busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          done_q, done_d;
  logic          sub_s;

`ifdef NIBBLE_ADD_SUBTRACT_EN
  assign sub_s = op_sub;
`else
  assign sub_s = 1'b0;
`endif

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          a_d     = op_a;
          // Subtraction is A + ~B + 1, so the injected carry replaces cin_in.
          b_d     = sub_s ? ~op_b : op_b;
          carry_d = sub_s ? 1'b1 : cin_in;
          idx_d   = '0;
          sum_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sum_d[4*idx_q +: 4] = adder_s;
        carry_d             = adder_c;
        if (idx_q == IDX_LAST) begin
          cout_d  = adder_c;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (done_ready) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  // Adder operand steering; the adder sees zeros whenever no slice is being computed.
  always_comb begin
    if (state_q == S_RUN) begin
      adder_a   = a_q[4*idx_q +: 4];
      adder_b   = b_q[4*idx_q +: 4];
      adder_cin = carry_q;
    end else begin
      adder_a   = 4'd0;
      adder_b   = 4'd0;
      adder_cin = 1'b0;
    end
  end

  assign start_ready = (state_q == S_IDLE) && !reset;
  assign busy        = (state_q != S_IDLE);
  assign sum         = sum_q;
  assign cout        = cout_q;
  assign done_valid  = done_q;

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
Sequencer that sits directly around the 4-bit ripple-carry adder. It feeds the adder one nibble pair per cycle and captures each nibble sum. The carry is chained through a register, so a wide addition runs on a single 4-bit adder instance. Operands arrive on a valid/ready request interface and the result leaves on a valid/ready response interface.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start_valid  input  1  request: operands valid.
start_ready  output  1  request accepted when start_valid && start_ready.
op_a  input  W  operand A, sampled on accept.
op_b  input  W  operand B, sampled on accept.
cin_in  input  1  initial carry, sampled on accept.
adder_a  output  4  nibble of A driven to the adder.
adder_b  output  4  nibble of B driven to the adder.
adder_cin  output  1  carry driven to the adder.
adder_s  input  4  adder sum, combinational from adder_a/adder_b/adder_cin.
adder_c  input  1  adder carry-out.
sum  output  W  registered result.
cout  output  1  registered final carry.
done_valid  output  1  result valid.
done_ready  input  1  consumer accepts result.
busy  output  1  high in RUN or DONE.

Behaviour:
- State machine has three states: IDLE, RUN, DONE. Encoding is free.
- Reset (async, any state) forces:
  - state to IDLE, idx to 0, carry_reg to 0, a_reg/b_reg to 0;
  - sum to 0, cout to 0, done_valid to 0, busy to 0;
  - adder_a/adder_b/adder_cin to 0;
  - start_ready to 1 once reset deasserts.
- IDLE: start_ready=1. On accept:
  - a_reg<=op_a, b_reg<=op_b, carry_reg<=cin_in, idx<=0, sum<=0;
  - next state RUN.
- RUN: start_ready=0.
  - Combinationally: adder_a=a_reg[4*idx+:4], adder_b=b_reg[4*idx+:4], adder_cin=carry_reg.
  - Each clock: sum[4*idx+:4]<=adder_s, carry_reg<=adder_c.
  - If idx==NIBBLES-1: cout<=adder_c and go to DONE; otherwise idx<=idx+1.
- RUN lasts exactly NIBBLES cycles. done_valid rises NIBBLES+1 clock edges after the accepting edge.
- Outside RUN, adder_a, adder_b and adder_cin are driven to 0.
- DONE: done_valid=1; sum and cout are held stable. When done_ready=1, go to IDLE and drop done_valid on that edge.
- A start request during DONE is not accepted (start_ready=0). The earliest accept is the cycle after the DONE-to-IDLE transition, so back-to-back throughput is one op per NIBBLES+2 cycles.
- Arithmetic is unsigned modulo 2^W. cout is the true carry out of bit W-1. No saturation.
- NIBBLES=1: RUN is a single cycle. idx width is max(1, clog2(NIBBLES)).
- done_ready held high in IDLE/RUN has no effect.
- Reset mid-RUN or mid-DONE abandons the operation. The result is never presented.

Optional Feature:
Macro NIBBLE_ADD_SUBTRACT_EN.
- Defined: extra input op_sub (1 bit), sampled on accept. If op_sub=1:
  - b_reg<=~op_b and carry_reg<=1; cin_in is ignored;
  - result is op_a-op_b mod 2^W;
  - cout=1 means no borrow (op_a>=op_b).
  - If op_sub=0, behaviour is identical to the undefined case.
- Not defined: op_sub port is absent; addition only.

Test Plan:
1. NIBBLES=4, op_a=0x1234, op_b=0x0FFF, cin_in=0, done_ready=1 -> done_valid rises 5 edges after accept, sum=0x2233, cout=0. adder_cin sequence over RUN is 0,1,1,1.
2. op_a=0xFFFF, op_b=0x0001, cin_in=0 -> sum=0x0000, cout=1. Repeat with op_b=0x0000, cin_in=1 -> same result.
3. Backpressure: done_ready=0 for 10 cycles after done_valid -> sum/cout/done_valid stable and start_ready=0 throughout. Raise done_ready -> IDLE next edge. A new start accepted on the following cycle completes correctly.
4. Reset asserted asynchronously during the 2nd RUN cycle (mid-clock) -> all outputs 0 immediately, no done_valid. The next request 0x0001+0x0001 yields 0x0002, cout=0.
5. NIBBLES=1: op_a=0x9, op_b=0x8, cin_in=1 -> sum=0x2, cout=1, done_valid 2 edges after accept.
6. With NIBBLE_ADD_SUBTRACT_EN, NIBBLES=4: op_sub=1, op_a=0x0005, op_b=0x0007 -> sum=0xFFFE, cout=0. op_a=0x0007, op_b=0x0005 -> sum=0x0002, cout=1.
